// File: rtl/scl_stall_arbiter_if.sv
// Requester/staller bundle for scl_stall_arbiter.
// master drives requests and staller done; slave is the arbiter.
interface scl_stall_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CYC_W   = 6
);
    logic [NUM_REQ-1:0]       i_req;
    logic [NUM_REQ*CYC_W-1:0] i_req_cycles;
    logic [NUM_REQ-1:0]       o_grant;
    logic [NUM_REQ-1:0]       o_done;
    logic                     o_err;
    logic                     o_stall_flag;
    logic [CYC_W-1:0]         o_stall_cycles;
    logic                     i_stall_done;
    logic                     o_busy;

    modport master (
        output i_req, i_req_cycles, i_stall_done,
        input  o_grant, o_done, o_err,
        input  o_stall_flag, o_stall_cycles, o_busy
    );

    modport slave (
        input  i_req, i_req_cycles, i_stall_done,
        output o_grant, o_done, o_err,
        output o_stall_flag, o_stall_cycles, o_busy
    );
endinterface

// File: rtl/scl_stall_arbiter.sv
// Round-robin owner of the shared scl_staller.
// Watchdog aborts a stall whose done never arrives.
module scl_stall_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CYC_W   = 6,
    parameter int TIMEOUT = 200
) (
    input  logic                i_sarb_clk,
    input  logic                i_sarb_rst,
    scl_stall_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [WD_W-1:0]    wd, wd_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [NUM_REQ-1:0] done, done_n;
    logic               err, err_n;
    logic               flag, flag_n;
    logic               busy, busy_n;
    logic [CYC_W-1:0]   cyc, cyc_n;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [CYC_W-1:0]   win_cyc;
    logic [NUM_REQ-1:0] win_oh;

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && bus.i_req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        win_cyc = bus.i_req_cycles[int'(win)*CYC_W +: CYC_W];
        win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        wd_n    = wd;
        grant_n = grant;
        done_n  = '0;
        err_n   = 1'b0;
        flag_n  = flag;
        cyc_n   = cyc;
        unique case (state)
            IDLE: begin
                grant_n = '0;
                if (found) begin
                    if (int'(win) == NUM_REQ - 1) ptr_n = '0;
                    else ptr_n = win + PTR_W'(1);
                    grant_n = win_oh;
                    if (win_cyc != '0) begin
                        cyc_n   = win_cyc;
                        flag_n  = 1'b1;
                        wd_n    = '0;
                        state_n = WAIT;
                    end else begin
                        done_n = win_oh;
                    end
                end
            end
            WAIT: begin
                // done beats a coincident timeout
                if (bus.i_stall_done || wd == WD_W'(TIMEOUT - 1)) begin
                    flag_n  = 1'b0;
                    grant_n = '0;
                    done_n  = grant;
                    err_n   = !bus.i_stall_done;
                    wd_n    = '0;
                    state_n = RELEASE;
                end else begin
                    wd_n = wd + WD_W'(1);
                end
            end
            RELEASE: begin
                if (!bus.i_stall_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge i_sarb_clk or posedge i_sarb_rst) begin
        if (i_sarb_rst) begin
            state <= IDLE;
            ptr   <= '0;
            wd    <= '0;
            grant <= '0;
            done  <= '0;
            err   <= 1'b0;
            flag  <= 1'b0;
            busy  <= 1'b0;
            cyc   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            wd    <= wd_n;
            grant <= grant_n;
            done  <= done_n;
            err   <= err_n;
            flag  <= flag_n;
            busy  <= busy_n;
            cyc   <= cyc_n;
        end
    end

    assign bus.o_grant        = grant;
    assign bus.o_done         = done;
    assign bus.o_err          = err;
    assign bus.o_stall_flag   = flag;
    assign bus.o_stall_cycles = cyc;
    assign bus.o_busy         = busy;
endmodule

// File: tb/tb_scl_stall_arbiter.sv
// Directed bench for scl_stall_arbiter with a small staller model.
// Outputs sampled 1ns after the rising edge.
module tb_scl_stall_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic       st_en = 1'b1;
    logic       st_done = 1'b0;
    int         st_cnt = 0;
    int         st_hold = 0;
    int         extra_hold = 0;

    scl_stall_arbiter_if #(.NUM_REQ(4), .CYC_W(6)) bus ();

    scl_stall_arbiter #(.NUM_REQ(4), .CYC_W(6), .TIMEOUT(16)) dut (
        .i_sarb_clk (clk),
        .i_sarb_rst (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_stall_done = st_done;

    // staller: done after o_stall_cycles flag clocks, held extra_hold clocks
    always @(negedge clk) begin
        if (rst || !st_en) begin
            st_done = 1'b0;
            st_cnt  = 0;
            st_hold = 0;
        end else if (bus.o_stall_flag && !st_done) begin
            st_cnt++;
            if (st_cnt >= int'(bus.o_stall_cycles)) begin
                st_done = 1'b1;
                st_hold = extra_hold;
            end
        end else if (st_done && !bus.o_stall_flag) begin
            if (st_hold == 0) begin
                st_done = 1'b0;
                st_cnt  = 0;
            end else begin
                st_hold--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cyc(input int k, input logic [5:0] c);
        bus.i_req_cycles[k*6 +: 6] = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req = '0;
        bus.i_req_cycles = '0;
        extra_hold = 0;
        st_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.i_req = '0;
        bus.i_req_cycles = '0;
        repeat (3) tick();
        checks++; if (bus.o_grant !== 4'b0) begin errors++; $display("FAIL rst_grant: got %b want 0000", bus.o_grant); end
        checks++; if (bus.o_done !== 4'b0) begin errors++; $display("FAIL rst_done: got %b want 0000", bus.o_done); end
        checks++; if (bus.o_stall_flag !== 1'b0) begin errors++; $display("FAIL rst_flag: got %b want 0", bus.o_stall_flag); end
        checks++; if (bus.o_stall_cycles !== 6'd0) begin errors++; $display("FAIL rst_cycles: got %0d want 0", bus.o_stall_cycles); end
        checks++; if ({bus.o_err, bus.o_busy} !== 2'b00) begin errors++; $display("FAIL rst_err_busy: got %b want 00", {bus.o_err, bus.o_busy}); end
        rst = 1'b0;
        tick();
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_single();
        do_reset();
        set_cyc(0, 6'd5);
        bus.i_req = 4'b0001;
        tick();
        checks++; if (bus.o_stall_flag !== 1'b1) begin errors++; $display("FAIL single_flag: got %b want 1", bus.o_stall_flag); end
        checks++; if (bus.o_stall_cycles !== 6'd5) begin errors++; $display("FAIL single_cycles: got %0d want 5", bus.o_stall_cycles); end
        checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", bus.o_grant); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.o_busy); end
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++; if ({bus.o_done, bus.o_stall_flag} !== 5'b0000_1) begin errors++; $display("FAIL single_wait%0d: got done=%b flag=%b want 0000/1", i, bus.o_done, bus.o_stall_flag); end
        end
        tick();
        checks++; if (bus.o_done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", bus.o_done); end
        checks++; if ({bus.o_stall_flag, bus.o_err} !== 2'b00) begin errors++; $display("FAIL single_flag_err: got %b want 00", {bus.o_stall_flag, bus.o_err}); end
        checks++; if ({bus.o_grant, bus.o_busy} !== 5'b0000_1) begin errors++; $display("FAIL single_release: got grant=%b busy=%b want 0000/1", bus.o_grant, bus.o_busy); end
        bus.i_req = '0;
        tick();
        checks++; if ({bus.o_done, bus.o_busy} !== 5'b0) begin errors++; $display("FAIL single_idle: got done=%b busy=%b want 0000/0", bus.o_done, bus.o_busy); end
    endtask

    task automatic test_round_robin();
        int exp_rr[6] = '{0, 1, 3, 0, 1, 3};
        int got[6];
        int n = 0;
        int low_run = 1;
        logic [3:0] prev_grant = '0;
        do_reset();
        for (int k = 0; k < 4; k++) set_cyc(k, 6'd3);
        bus.i_req = 4'b1011;
        for (int t = 0; t < 200 && n < 6; t++) begin
            tick();
            if (bus.o_grant != 4'b0 && prev_grant == 4'b0) begin
                checks++; if (low_run < 1) begin errors++; $display("FAIL rr_gap: got %0d low clocks want >=1", low_run); end
            end
            low_run = bus.o_stall_flag ? 0 : low_run + 1;
            if (bus.o_done != 4'b0) begin
                got[n] = oh_idx(bus.o_done);
                n++;
            end
            prev_grant = bus.o_grant;
        end
        bus.i_req = '0;
        checks++; if (n != 6) begin errors++; $display("FAIL rr_count: got %0d dones want 6", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] != exp_rr[i]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, got[i], exp_rr[i]); end
        end
    endtask

    task automatic test_zero_cycle();
        do_reset();
        set_cyc(2, 6'd0);
        set_cyc(1, 6'd7);
        bus.i_req = 4'b0100;
        tick();
        checks++; if (bus.o_grant !== 4'b0100) begin errors++; $display("FAIL zero_grant: got %b want 0100", bus.o_grant); end
        checks++; if (bus.o_done !== 4'b0100) begin errors++; $display("FAIL zero_done: got %b want 0100", bus.o_done); end
        checks++; if ({bus.o_stall_flag, bus.o_busy, bus.o_err} !== 3'b000) begin errors++; $display("FAIL zero_flag_busy: got %b want 000", {bus.o_stall_flag, bus.o_busy, bus.o_err}); end
        bus.i_req = '0;
        tick();
        checks++; if ({bus.o_grant, bus.o_done, bus.o_busy} !== 9'b0) begin errors++; $display("FAIL zero_after: got grant=%b done=%b busy=%b want 0", bus.o_grant, bus.o_done, bus.o_busy); end
    endtask

    task automatic test_timeout();
        do_reset();
        st_en = 1'b0;
        set_cyc(1, 6'd9);
        bus.i_req = 4'b0010;
        tick();
        checks++; if ({bus.o_grant, bus.o_stall_flag} !== 5'b0010_1) begin errors++; $display("FAIL to_grant: got grant=%b flag=%b want 0010/1", bus.o_grant, bus.o_stall_flag); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if ({bus.o_done, bus.o_err, bus.o_stall_flag} !== 6'b0000_0_1) begin errors++; $display("FAIL to_wait%0d: got done=%b err=%b flag=%b want 0000/0/1", i, bus.o_done, bus.o_err, bus.o_stall_flag); end
        end
        tick();
        checks++; if (bus.o_done !== 4'b0010) begin errors++; $display("FAIL to_done: got %b want 0010", bus.o_done); end
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bus.o_err); end
        checks++; if ({bus.o_stall_flag, bus.o_grant} !== 5'b0) begin errors++; $display("FAIL to_flag: got flag=%b grant=%b want 0/0000", bus.o_stall_flag, bus.o_grant); end
        bus.i_req = '0;
        tick();
        checks++; if ({bus.o_err, bus.o_busy, bus.o_done} !== 6'b0) begin errors++; $display("FAIL to_idle: got err=%b busy=%b done=%b want 0", bus.o_err, bus.o_busy, bus.o_done); end
        st_en = 1'b1;
    endtask

    task automatic test_done_held();
        do_reset();
        extra_hold = 4;
        set_cyc(0, 6'd2);
        set_cyc(2, 6'd3);
        bus.i_req = 4'b0101;
        tick();
        checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL hold_grant0: got %b want 0001", bus.o_grant); end
        tick();
        tick();
        checks++; if (bus.o_done !== 4'b0001) begin errors++; $display("FAIL hold_done0: got %b want 0001", bus.o_done); end
        bus.i_req = 4'b0100;
        for (int i = 3; i <= 6; i++) begin
            tick();
            checks++; if ({bus.o_busy, bus.o_grant, bus.o_stall_flag, bus.o_done} !== 10'b1_0000_0_0000) begin errors++; $display("FAIL hold_release%0d: got busy=%b grant=%b flag=%b done=%b want 1/0000/0/0000", i, bus.o_busy, bus.o_grant, bus.o_stall_flag, bus.o_done); end
        end
        tick();
        checks++; if ({bus.o_busy, bus.o_grant} !== 5'b0) begin errors++; $display("FAIL hold_idle: got busy=%b grant=%b want 0/0000", bus.o_busy, bus.o_grant); end
        tick();
        checks++; if ({bus.o_grant, bus.o_stall_flag} !== 5'b0100_1) begin errors++; $display("FAIL hold_grant2: got grant=%b flag=%b want 0100/1", bus.o_grant, bus.o_stall_flag); end
        checks++; if (bus.o_stall_cycles !== 6'd3) begin errors++; $display("FAIL hold_cycles2: got %0d want 3", bus.o_stall_cycles); end
        extra_hold = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cyc(3, 6'd20);
        set_cyc(1, 6'd2);
        set_cyc(2, 6'd2);
        set_cyc(0, 6'd2);
        bus.i_req = 4'b1000;
        tick();
        checks++; if ({bus.o_grant, bus.o_stall_flag} !== 5'b1000_1) begin errors++; $display("FAIL mid_grant3: got grant=%b flag=%b want 1000/1", bus.o_grant, bus.o_stall_flag); end
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++; if ({bus.o_stall_flag, bus.o_grant, bus.o_busy} !== 6'b0) begin errors++; $display("FAIL mid_clear: got flag=%b grant=%b busy=%b want 0", bus.o_stall_flag, bus.o_grant, bus.o_busy); end
        bus.i_req = 4'b0110;
        tick();
        tick();
        checks++; if (bus.o_done !== 4'b0) begin errors++; $display("FAIL mid_nodone: got %b want 0000", bus.o_done); end
        rst = 1'b0;
        tick();
        checks++; if (bus.o_grant !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", bus.o_grant); end
        rst = 1'b1;
        #1;
        bus.i_req = 4'b0101;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL mid_ptr0: got %b want 0001", bus.o_grant); end
        bus.i_req = '0;
    endtask

    initial begin
        bus.i_req = '0;
        bus.i_req_cycles = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_cycle();
        test_timeout();
        test_done_held();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scl_stall_arbiter.md
Name: scl_stall_arbiter

Overview:
- Shares the single scl_staller between up to NUM_REQ Tx-side requesters, for example the SDR FSM, the HDR-DDR FSM and the CCC engine.
- Grants requesters round-robin and drives the staller's flag/cycles inputs.
- Waits for the staller's done, then returns a per-requester done pulse.
- A watchdog aborts a stall that never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CYC_W, 6, width of stall-cycle count; matches the staller's cycles input.
- TIMEOUT, 200, maximum clocks spent in WAIT before abort.

Ports:
- i_sarb_clk  in  1  system clock.
- i_sarb_rst  in  1  reset, asynchronous, active-high.
- i_req  in  NUM_REQ  per-requester stall request (level).
- i_req_cycles  in  NUM_REQ*CYC_W  packed cycle counts; requester k uses bits [k*CYC_W +: CYC_W].
- o_grant  out  NUM_REQ  one-hot current owner.
- o_done  out  NUM_REQ  one-clock completion pulse to the owner.
- o_err  out  1  one-clock pulse coincident with o_done when the stall timed out.
- o_stall_flag  out  1  to staller flag input.
- o_stall_cycles  out  CYC_W  to staller cycles input.
- i_stall_done  in  1  from staller done output.
- o_busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, i_sarb_clk. i_sarb_rst is asynchronous and active-high.
- Reset values: all outputs are 0, state is IDLE, RR pointer is 0, watchdog is 0, latched cycles are 0. Assertion mid-stall clears everything immediately; o_stall_flag drops without a done pulse.
- All outputs are registered.
- States:
  - IDLE: o_stall_flag=0, o_grant=0.
  - WAIT: stall in progress.
  - RELEASE: staller re-arm.
- Arbitration (IDLE only):
  - Search i_req starting at index ptr and wrapping upward; the first set bit wins (winner g).
  - On the next edge ptr becomes (g+1) mod NUM_REQ.
  - Requests arriving in WAIT or RELEASE wait; no preemption.
- Grant, cycles nonzero:
  - On the edge after IDLE samples i_req[g]=1, the following take effect together:
    - i_req_cycles[g] is latched into o_stall_cycles.
    - o_grant[g]=1.
    - o_stall_flag=1.
    - The state becomes WAIT.
  - Latency from request to flag is 1 clock.
- Grant, cycles zero:
  - The staller is not engaged.
  - On that edge, o_grant[g]=1 and o_done[g]=1 for one clock; the state stays IDLE.
  - The pointer advances.
- WAIT:
  - o_stall_flag and o_stall_cycles are held constant.
  - The watchdog increments each clock.
  - When i_stall_done is sampled 1:
    - Next edge: o_stall_flag=0, o_grant=0, o_done[g]=1 for one clock, state RELEASE.
  - When the watchdog reaches TIMEOUT-1 and i_stall_done is 0:
    - Same exit as a normal done, plus o_err=1 for that clock.
  - If i_stall_done=1 and the timeout hit the same clock, done wins and o_err=0.
- RELEASE:
  - Minimum 1 clock.
  - Stays while i_stall_done=1 so the staller sees flag low and clears.
  - Goes to IDLE on the edge after i_stall_done is sampled 0.
  - The watchdog clears on entry.
- Requester rule:
  - Hold i_req[k] and its cycles stable until o_done[k].
  - Drop i_req[k] the clock after o_done[k].
  - A still-high request is treated as a new request, which round-robin serves only after the other pending requesters.
- Deassert before grant: a requester dropping i_req before it is granted is simply not served.
- Deassert after grant: dropping i_req after grant does not abort the stall.
- o_busy is 1 in WAIT and RELEASE.

Test Plan:
- Single request:
  - Stimulus: reset for 3 clocks, then i_req=0001 with cycles 5; the staller asserts done after 5 stall clocks.
  - Required response: o_stall_flag rises 1 clock after request with o_stall_cycles=5 and o_grant=0001.
  - After done, exactly one o_done[0] pulse, flag low, RELEASE then IDLE; o_err=0.
- Round-robin:
  - Stimulus: i_req=1011 held continuously, each requester with cycles 3.
  - Required response: grant order 0,1,3,0,1,3.
  - Each grant is preceded by at least 1 clock of flag low (RELEASE).
- Zero-cycle request:
  - Stimulus: i_req=0100 with cycles 0.
  - Required response: o_grant=0100 and o_done[2] pulse on the same clock; o_stall_flag stays 0; o_busy stays 0.
- Timeout:
  - Stimulus: TIMEOUT=16, requester 1 with cycles 9, staller done tied 0.
  - Required response: after 16 clocks in WAIT, o_done[1]=1 and o_err=1 for one clock; flag drops; state returns to IDLE.
- Done held high:
  - Stimulus: the staller keeps done=1 for 4 clocks after flag drops, while requester 2 is pending.
  - Required response: the arbiter stays in RELEASE until done=0, and only then grants requester 2.
- Reset mid-stall:
  - Stimulus: assert i_sarb_rst asynchronously during WAIT with requester 3 active.
  - Required response: o_stall_flag, o_grant and o_busy go to 0 immediately; no o_done pulse.
  - After release, the first pending request is served starting from ptr 0.
